// File: rtl/spi_gcd_minion_if.sv
// Bundles the SPI pins and the GCD val/rdy request/response channels of the minion.
interface spi_gcd_minion_if #(
  parameter int unsigned DATA_W = 32
);
  logic              spi_csb;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_miso;
  logic [DATA_W-1:0] push_msg;
  logic              push_val;
  logic              push_rdy;
  logic [DATA_W-1:0] pull_msg;
  logic              pull_val;
  logic              pull_rdy;

  modport slave (
    input  spi_csb, spi_sclk, spi_mosi, push_rdy, pull_msg, pull_val,
    output spi_miso, push_msg, push_val, pull_rdy
  );

  modport master (
    output spi_csb, spi_sclk, spi_mosi, push_rdy, pull_msg, pull_val,
    input  spi_miso, push_msg, push_val, pull_rdy
  );
endinterface

// File: rtl/spi_gcd_minion.sv
// SPI mode-0 minion bridging fixed-length packets {val, rdy, data} to the GCD
// request (push) and response (pull) val/rdy channels, all in the clock domain.
module spi_gcd_minion #(
  parameter int unsigned DATA_W = 32
) (
  input  logic            clock,
  input  logic            resetb,
  spi_gcd_minion_if.slave bus
);
  localparam int unsigned N  = DATA_W + 2;
  localparam int unsigned CW = $clog2(N + 2);
  localparam logic [CW-1:0] CNT_N   = CW'(N);
  localparam logic [CW-1:0] CNT_MAX = CW'(N + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state, state_n;

  logic csb_s1, csb_s2, csb_s3;
  logic sclk_s1, sclk_s2, sclk_s3;
  logic mosi_s1, mosi_s2;

  logic [N-1:0]      tx;
  logic [N-1:0]      rx;
  logic [CW-1:0]     cnt;
  logic              adv_val;
  logic              adv_rdy;
  logic              full;
  logic [DATA_W-1:0] pbuf;
  logic              pull_rdy_q;

  logic csb_fall, csb_rise, sclk_rise, sclk_fall;
  logic start, finish, pkt_ok, do_push, do_pop;

  // Synchronisers; the third stage only serves edge detection.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      csb_s1  <= 1'b1;
      csb_s2  <= 1'b1;
      csb_s3  <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      csb_s1  <= bus.spi_csb;
      csb_s2  <= csb_s1;
      csb_s3  <= csb_s2;
      sclk_s1 <= bus.spi_sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      mosi_s1 <= bus.spi_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign csb_fall  =  csb_s3  & ~csb_s2;
  assign csb_rise  = ~csb_s3  &  csb_s2;
  assign sclk_rise = ~sclk_s3 &  sclk_s2;
  assign sclk_fall =  sclk_s3 & ~sclk_s2;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        if (csb_fall) begin
          state_n = SHIFT;
          start   = 1'b1;
        end
      end
      SHIFT: begin
        if (csb_rise) begin
          state_n = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    pkt_ok  = finish && (cnt == CNT_N);
    do_push = pkt_ok && rx[N-1] && adv_rdy;
    do_pop  = pkt_ok && rx[N-2] && adv_val;
  end

  // Shift registers, advertised flow-control snapshot and bit counter.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      tx      <= '0;
      rx      <= '0;
      cnt     <= '0;
      adv_val <= 1'b0;
      adv_rdy <= 1'b0;
    end else if (start) begin
      adv_val <= bus.pull_val;
      adv_rdy <= ~full;
      tx      <= {bus.pull_val, ~full, bus.pull_msg};
      cnt     <= '0;
    end else if (state == SHIFT) begin
      if (sclk_rise) begin
        rx <= {rx[N-2:0], mosi_s2};
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end
      if (sclk_fall) tx <= {tx[N-2:0], 1'b0};
    end
  end

  // A load only happens when the buffer was advertised empty, so it never
  // coincides with a drain handshake.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      full       <= 1'b0;
      pbuf       <= '0;
      pull_rdy_q <= 1'b0;
    end else begin
      pull_rdy_q <= do_pop;
      if (do_push) begin
        full <= 1'b1;
        pbuf <= rx[DATA_W-1:0];
      end else if (full && bus.push_rdy) begin
        full <= 1'b0;
      end
    end
  end

  assign bus.spi_miso = (state == SHIFT) ? tx[N-1] : 1'b0;
  assign bus.push_val = full;
  assign bus.push_msg = pbuf;
  assign bus.pull_rdy = pull_rdy_q;
endmodule

// File: tb/tb_spi_gcd_minion.sv
// Self-checking bench for spi_gcd_minion: directed scenarios plus randomised
// traffic against a packet-level model of the push buffer and pull pops.
module tb_spi_gcd_minion;
  localparam int unsigned DW = 32;
  localparam int unsigned N  = DW + 2;

  logic clock  = 1'b0;
  logic resetb = 1'b0;
  always #5 clock = ~clock;

  spi_gcd_minion_if #(.DATA_W(DW)) bus();
  spi_gcd_minion #(.DATA_W(DW)) dut (.clock(clock), .resetb(resetb), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] push_log[$];
  int push_cyc  = 0;
  int pull_n    = 0;
  int pull_cyc  = 0;
  int pushval_n = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (resetb) begin
      if (bus.push_val && bus.push_rdy) begin
        push_log.push_back(bus.push_msg);
        push_cyc = cyc;
      end
      if (bus.push_val) pushval_n++;
      if (bus.pull_rdy) begin
        pull_n++;
        pull_cyc = cyc;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic sclk_bit(input logic m, output logic s);
    bus.spi_mosi = m;
    tick(6);
    bus.spi_sclk = 1'b1;
    s = bus.spi_miso;
    tick(6);
    bus.spi_sclk = 1'b0;
  endtask

  task automatic spi_xfer(input int nclk, input logic [N-1:0] tx,
                          output logic [N-1:0] rx, output int rise_cyc);
    logic s;
    rx = '0;
    bus.spi_csb = 1'b0;
    tick(6);
    for (int i = 0; i < nclk; i++) begin
      sclk_bit((i < int'(N)) ? tx[int'(N) - 1 - i] : 1'b0, s);
      rx = {rx[N-2:0], s};
    end
    tick(6);
    bus.spi_csb = 1'b1;
    rise_cyc = cyc;
    tick(10);
  endtask

  task automatic test_reset;
    resetb = 1'b0;
    tick(3);
    total++; if (bus.spi_miso !== 1'b0) begin bad++; $display("FAIL reset_miso: got %b want 0", bus.spi_miso); end
    total++; if (bus.push_val !== 1'b0) begin bad++; $display("FAIL reset_push_val: got %b want 0", bus.push_val); end
    total++; if (bus.push_msg !== '0) begin bad++; $display("FAIL reset_push_msg: got %h want 0", bus.push_msg); end
    total++; if (bus.pull_rdy !== 1'b0) begin bad++; $display("FAIL reset_pull_rdy: got %b want 0", bus.pull_rdy); end
    resetb = 1'b1;
    tick(4);
  endtask

  task automatic test_write;
    logic [N-1:0] rx;
    int rc, base, pv, pn;
    bus.push_rdy = 1'b1;
    bus.pull_val = 1'b0;
    base = push_log.size(); pv = pushval_n; pn = pull_n;
    spi_xfer(N, {1'b1, 1'b0, 32'h0000_0030}, rx, rc);
    total++; if (rx[N-1 -: 2] !== 2'b01) begin bad++; $display("FAIL write_flags: got %b want 01", rx[N-1 -: 2]); end
    total++; if (push_log.size() - base != 1) begin bad++; $display("FAIL write_push_count: got %0d want 1", push_log.size() - base); end
    else begin
      total++; if (push_log[base] !== 32'h30) begin bad++; $display("FAIL write_push_msg: got %h want 00000030", push_log[base]); end
      total++; if (push_cyc - rc < 2 || push_cyc - rc > 5) begin bad++; $display("FAIL write_latency: got %0d want 2..5", push_cyc - rc); end
    end
    total++; if (pushval_n - pv != 1) begin bad++; $display("FAIL write_val_cycles: got %0d want 1", pushval_n - pv); end
    total++; if (pull_n - pn != 0) begin bad++; $display("FAIL write_no_pull: got %0d want 0", pull_n - pn); end
  endtask

  task automatic test_backpressure;
    logic [N-1:0] rx;
    int rc, base;
    bus.push_rdy = 1'b0;
    base = push_log.size();
    spi_xfer(N, {1'b1, 1'b0, 32'h11}, rx, rc);
    total++; if (rx[N-2] !== 1'b1) begin bad++; $display("FAIL bp_first_rdy: got %b want 1", rx[N-2]); end
    total++; if (bus.push_val !== 1'b1 || bus.push_msg !== 32'h11) begin bad++; $display("FAIL bp_held: got val=%b msg=%h want val=1 msg=00000011", bus.push_val, bus.push_msg); end
    spi_xfer(N, {1'b1, 1'b0, 32'h22}, rx, rc);
    total++; if (rx[N-2] !== 1'b0) begin bad++; $display("FAIL bp_second_rdy: got %b want 0", rx[N-2]); end
    total++; if (bus.push_msg !== 32'h11) begin bad++; $display("FAIL bp_not_overwritten: got %h want 00000011", bus.push_msg); end
    bus.push_rdy = 1'b1;
    tick(4);
    total++; if (push_log.size() - base != 1) begin bad++; $display("FAIL bp_drain_count: got %0d want 1", push_log.size() - base); end
    else begin
      total++; if (push_log[base] !== 32'h11) begin bad++; $display("FAIL bp_drain_msg: got %h want 00000011", push_log[base]); end
    end
    total++; if (bus.push_val !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", bus.push_val); end
  endtask

  task automatic test_read;
    logic [N-1:0] rx;
    int rc, base, pn;
    bus.pull_val = 1'b1;
    bus.pull_msg = 32'h0000_000A;
    base = push_log.size(); pn = pull_n;
    spi_xfer(N, {1'b0, 1'b1, 32'h0}, rx, rc);
    total++; if (rx[N-1] !== 1'b1) begin bad++; $display("FAIL read_adv_val: got %b want 1", rx[N-1]); end
    total++; if (rx[DW-1:0] !== 32'hA) begin bad++; $display("FAIL read_data: got %h want 0000000a", rx[DW-1:0]); end
    total++; if (pull_n - pn != 1) begin bad++; $display("FAIL read_pull_count: got %0d want 1", pull_n - pn); end
    else begin
      total++; if (pull_cyc - rc < 2 || pull_cyc - rc > 5) begin bad++; $display("FAIL read_latency: got %0d want 2..5", pull_cyc - rc); end
    end
    total++; if (push_log.size() - base != 0) begin bad++; $display("FAIL read_no_push: got %0d want 0", push_log.size() - base); end
    bus.pull_val = 1'b0;
  endtask

  task automatic test_combined;
    logic [N-1:0] rx;
    int rc, base, pn;
    bus.push_rdy = 1'b1;
    bus.pull_val = 1'b1;
    bus.pull_msg = 32'h5;
    base = push_log.size(); pn = pull_n;
    spi_xfer(N, {1'b1, 1'b1, 32'h15}, rx, rc);
    total++; if (rx !== {1'b1, 1'b1, 32'h5}) begin bad++; $display("FAIL comb_miso: got %h want %h", rx, {1'b1, 1'b1, 32'h5}); end
    total++; if (push_log.size() - base != 1 || pull_n - pn != 1) begin bad++; $display("FAIL comb_counts: got push=%0d pull=%0d want 1 1", push_log.size() - base, pull_n - pn); end
    else begin
      total++; if (push_log[base] !== 32'h15) begin bad++; $display("FAIL comb_push_msg: got %h want 00000015", push_log[base]); end
      total++; if (push_cyc != pull_cyc) begin bad++; $display("FAIL comb_same_cycle: got push@%0d pull@%0d want equal", push_cyc, pull_cyc); end
    end
    bus.pull_val = 1'b0;
  endtask

  task automatic test_bad_length;
    logic [N-1:0] rx;
    int rc, base, pn;
    int lens[2];
    lens[0] = int'(N) - 1;
    lens[1] = int'(N) + 1;
    bus.push_rdy = 1'b1;
    bus.pull_val = 1'b1;
    bus.pull_msg = $urandom;
    foreach (lens[k]) begin
      base = push_log.size(); pn = pull_n;
      spi_xfer(lens[k], {1'b1, 1'b1, 32'($urandom)}, rx, rc);
      total++; if (push_log.size() - base != 0) begin bad++; $display("FAIL badlen_push len=%0d: got %0d want 0", lens[k], push_log.size() - base); end
      total++; if (pull_n - pn != 0) begin bad++; $display("FAIL badlen_pull len=%0d: got %0d want 0", lens[k], pull_n - pn); end
    end
    bus.pull_val = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [N-1:0] rx;
    logic [N-1:0] pkt;
    logic s;
    int rc, base, pn;
    bus.push_rdy = 1'b0;
    bus.pull_val = 1'b1;
    spi_xfer(N, {1'b1, 1'b0, 32'h55}, rx, rc);
    total++; if (bus.push_val !== 1'b1) begin bad++; $display("FAIL rmid_preload: got %b want 1", bus.push_val); end
    pkt = {1'b1, 1'b1, 32'h0000_0009};
    base = push_log.size(); pn = pull_n;
    bus.spi_csb = 1'b0;
    tick(6);
    for (int i = 0; i < 10; i++) sclk_bit(pkt[int'(N) - 1 - i], s);
    resetb = 1'b0;
    tick(2);
    total++; if ({bus.spi_miso, bus.push_val, bus.pull_rdy} !== 3'b000 || bus.push_msg !== '0) begin
      bad++; $display("FAIL rmid_outputs: got miso=%b val=%b rdy=%b msg=%h want all 0", bus.spi_miso, bus.push_val, bus.pull_rdy, bus.push_msg);
    end
    tick(2);
    resetb = 1'b1;
    for (int i = 10; i < int'(N); i++) sclk_bit(pkt[int'(N) - 1 - i], s);
    tick(6);
    bus.spi_csb = 1'b1;
    tick(10);
    total++; if (bus.push_val !== 1'b0 || push_log.size() - base != 0) begin bad++; $display("FAIL rmid_partial_push: got val=%b n=%0d want 0 0", bus.push_val, push_log.size() - base); end
    total++; if (pull_n - pn != 0) begin bad++; $display("FAIL rmid_partial_pull: got %0d want 0", pull_n - pn); end
    bus.pull_val = 1'b0;
    bus.push_rdy = 1'b1;
    base = push_log.size();
    spi_xfer(N, {1'b1, 1'b0, 32'h7}, rx, rc);
    total++; if (push_log.size() - base != 1) begin bad++; $display("FAIL rmid_after_count: got %0d want 1", push_log.size() - base); end
    else begin
      total++; if (push_log[base] !== 32'h7) begin bad++; $display("FAIL rmid_after_msg: got %h want 00000007", push_log[base]); end
    end
  endtask

  task automatic test_random_traffic;
    logic [N-1:0] rx;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_buf, data, pmsg;
    logic m_full, r, pv, mval, mrdy, arw, valid;
    int rc, base, pn, len, exp_pull;
    m_full = 1'b0;
    m_buf  = '0;
    for (int it = 0; it < 12; it++) begin
      exp_q.delete();
      base = push_log.size(); pn = pull_n;
      r = 1'($urandom_range(0, 1));
      bus.push_rdy = r;
      tick(4);
      if (r && m_full) begin exp_q.push_back(m_buf); m_full = 1'b0; end
      pv   = 1'($urandom_range(0, 1));
      pmsg = $urandom;
      bus.pull_val = pv;
      bus.pull_msg = pmsg;
      mval = 1'($urandom_range(0, 1));
      mrdy = 1'($urandom_range(0, 1));
      data = $urandom;
      case ($urandom_range(0, 4))
        0: len = int'(N) - 1;
        1: len = int'(N) + 1;
        default: len = int'(N);
      endcase
      valid = (len == int'(N));
      arw = ~m_full;
      spi_xfer(len, {mval, mrdy, data}, rx, rc);
      if (valid) begin
        total++; if (rx !== {pv, arw, pmsg}) begin bad++; $display("FAIL rand_miso it=%0d: got %h want %h", it, rx, {pv, arw, pmsg}); end
      end
      if (valid && mval && arw) begin
        m_full = 1'b1; m_buf = data;
        if (r) begin exp_q.push_back(data); m_full = 1'b0; end
      end
      exp_pull = (valid && mrdy && pv) ? 1 : 0;
      total++; if (push_log.size() - base != exp_q.size()) begin bad++; $display("FAIL rand_push_count it=%0d: got %0d want %0d", it, push_log.size() - base, exp_q.size()); end
      else begin
        foreach (exp_q[k]) begin
          total++; if (push_log[base + k] !== exp_q[k]) begin bad++; $display("FAIL rand_push_msg it=%0d: got %h want %h", it, push_log[base + k], exp_q[k]); end
        end
      end
      total++; if (pull_n - pn != exp_pull) begin bad++; $display("FAIL rand_pull it=%0d: got %0d want %0d", it, pull_n - pn, exp_pull); end
      total++; if (bus.push_val !== m_full) begin bad++; $display("FAIL rand_full it=%0d: got %b want %b", it, bus.push_val, m_full); end
    end
    base = push_log.size();
    bus.push_rdy = 1'b1;
    bus.pull_val = 1'b0;
    tick(4);
    total++; if (push_log.size() - base != (m_full ? 1 : 0)) begin bad++; $display("FAIL rand_final_drain: got %0d want %0d", push_log.size() - base, m_full ? 1 : 0); end
  endtask

  initial begin
    bus.spi_csb  = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.push_rdy = 1'b0;
    bus.pull_msg = '0;
    bus.pull_val = 1'b0;
    test_reset();
    test_write();
    test_backpressure();
    test_read();
    test_combined();
    test_bad_length();
    test_reset_mid();
    test_random_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_gcd_minion.md
# spi_gcd_minion

SPI responder (minion) that terminates the SPI link driven by the RISC-V firmware and bridges it to the GCD accelerator's latency-insensitive val/rdy interfaces. Each fixed-length SPI packet can carry one request message into the accelerator and one response message out of it. Packet-level flow-control bits let the firmware poll for buffer space and response availability. The block sits inside the user project area between the mprj_io SPI pins and the GCD unit, in the `clock` domain.

## Interface
- `DATA_W`, 32: message payload width; packet length N = DATA_W+2 bits.
- `clock`  input  1  system clock; all state is in this domain.
- `resetb`  input  1  asynchronous, active-low reset.
- `spi_csb`  input  1  chip select, active low, asynchronous to `clock`.
- `spi_sclk`  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to `clock`.
- `spi_mosi`  input  1  data from the master, MSB first.
- `spi_miso`  output  1  data to the master, MSB first.
- `push_msg`  output  DATA_W  request message to GCD.
- `push_val`  output  1  `push_msg` valid.
- `push_rdy`  input  1  GCD accepts the request.
- `pull_msg`  input  DATA_W  response message from GCD.
- `pull_val`  input  1  response valid.
- `pull_rdy`  output  1  one-cycle pop of the response.

## Operation
- Synchronisation:
  - `spi_csb`, `spi_sclk` and `spi_mosi` each pass through a 2-flop synchroniser.
  - A third register provides edge detection: `csb` fall/rise and `sclk` rise/fall strobes.
- States: IDLE, SHIFT.
- IDLE → SHIFT on a csb-fall strobe. In the same cycle:
  - Snapshot `adv_val` = `pull_val`.
  - Snapshot `adv_rdy` = push buffer empty and not being loaded.
  - Load the TX shift register with {`adv_val`, `adv_rdy`, `pull_msg`}.
  - Clear the bit counter.
- SHIFT:
  - On an sclk-rise strobe: shift the synchronised mosi into the RX register LSB and increment the bit counter. The counter saturates at N+1.
  - On an sclk-fall strobe: shift the TX register left, filling with 0.
  - `spi_miso` = TX register MSB while in SHIFT, 0 in IDLE.
- SHIFT → IDLE on a csb-rise strobe.
  - Valid packet: exactly N rises counted. RX = {m_val, m_rdy, data}.
    - If m_val and `adv_rdy`: load the push buffer with `data` and set full.
    - If m_rdy and `adv_val`: assert `pull_rdy` for exactly one cycle.
  - Invalid packet: any other count. Discard it; no push, no pop.
- Push buffer: single entry.
  - `push_val` = full, and `push_msg` = buffer contents.
  - Clears on `push_val && push_rdy`.
- m_val with `adv_rdy`=0 is dropped silently. The firmware must retry.
- `pull_msg` stays stable while `pull_val` is high (val/rdy rule), so the snapshot data and the popped message are the same one.

## Timing
- Reset values:
  - Outputs: `spi_miso`=0, `push_val`=0, `push_msg`=0, `pull_rdy`=0.
  - Internal: state=IDLE, counter=0, TX/RX=0, buffer empty.
  - Synchroniser flops reset to csb=1, sclk=0, mosi=0.
- Pin-to-strobe latency: 3 `clock` cycles.
- Packet end to outputs: `push_val` rises and/or the `pull_rdy` pulse occurs on the cycle after the csb-rise strobe, i.e. 4 cycles after the `spi_csb` pin rises.
- `spi_miso` updates 3–4 cycles after a `spi_sclk` pin fall. The first bit is valid 4 cycles after the `spi_csb` fall.
- Constraints on the master:
  - sclk high and low phases ≥ 4 `clock` cycles.
  - csb setup to the first sclk rise ≥ 4 cycles.
  - csb-high gap between packets ≥ 4 cycles.
- Buffer full at a csb fall gives `adv_rdy`=0.
- Buffer draining in the same cycle as a csb fall also gives `adv_rdy`=0 (conservative).
- Push handshake in the same cycle as a packet load cannot happen, because `adv_rdy` required the buffer to be empty.
- `resetb` low mid-packet: immediate return to IDLE, buffer cleared. A partial packet after reset release is ignored until the next csb fall.
- Never more than one `pull_rdy` pulse per packet.

## Test plan
- Write: send packet {1,0,0x0000_0030} with `push_rdy`=1. Expect returned bits 1,2 = {0,1}, `push_val` for 1 cycle with `push_msg`=0x0000_0030, and no `pull_rdy`.
- Backpressure:
  - Hold `push_rdy`=0 and write 0x11. Buffer holds 0x11.
  - Second write of 0x22: returned bit 2 = 0, 0x22 dropped.
  - Raise `push_rdy`: exactly one 0x11 handshake.
- Read: set `pull_val`=1, `pull_msg`=0x0000_000A, send {0,1,0}. Expect MISO stream {1, x, 0x0000_000A} and a single `pull_rdy` pulse 4 cycles after csb rises.
- Combined: send {1,1,0x0000_0015} with `pull_val`=1, `pull_msg`=0x5. Expect one push of 0x15 and one `pull_rdy` pulse in the same cycle.
- Bad length: packets of 33 and 35 clocks with m_val=m_rdy=1. Expect no push and no `pull_rdy`.
- Reset mid-packet: drop `resetb` after 10 sclk rises. Expect all outputs 0 during reset; the next full write of 0x7 pushes 0x7 correctly.
